// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: in-order record of predicted branches, resolved against execute outcomes.
// Optional BRQ_STATS_EN adds resolved/mispredict event counters.
module branch_resolve_queue #(
  parameter int DEPTH    = 4,
  parameter int HIST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  input  logic [31:0]                enq_pc,
  input  logic                       enq_pred_taken,
  input  logic [31:0]                enq_pred_target,
  input  logic [HIST_LEN-1:0]        enq_hist,
  output logic                       enq_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [31:0]                res_target,
  output logic                       upd_valid,
  output logic [31:0]                upd_pc,
  output logic                       upd_taken,
  output logic [HIST_LEN-1:0]        upd_hist,
  output logic                       mis_predict,
  output logic [31:0]                redirect_pc,
`ifdef BRQ_STATS_EN
  output logic [31:0]                stat_resolved,
  output logic [31:0]                stat_mispred,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]         pc_q   [DEPTH];
  logic                pt_q   [DEPTH];
  logic [31:0]         tgt_q  [DEPTH];
  logic [HIST_LEN-1:0] hist_q [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic                upd_valid_q, upd_taken_q, mis_q;
  logic [31:0]         upd_pc_q, redirect_q;
  logic [HIST_LEN-1:0] upd_hist_q;

  logic enq_fire, res_fire, mis;
  logic [31:0] head_pc, head_tgt;
  logic head_pt;

  assign enq_ready = (count_q < CW'(DEPTH));
  assign enq_fire  = enq_valid && enq_ready;
  assign res_fire  = res_valid && (count_q != '0);
  assign head_pc   = pc_q[head_q];
  assign head_pt   = pt_q[head_q];
  assign head_tgt  = tgt_q[head_q];
  assign mis       = res_fire && ((head_pt != res_taken) ||
                                  (res_taken && (head_tgt != res_target)));

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mis) begin
      // Everything younger than the resolved branch is wrong-path, including this cycle's enqueue.
      head_d  = head_q + PW'(1);
      tail_d  = head_q + PW'(1);
      count_d = '0;
    end else begin
      if (res_fire) head_d = head_q + PW'(1);
      if (enq_fire) tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(enq_fire) - CW'(res_fire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_taken_q <= 1'b0;
      mis_q       <= 1'b0;
      upd_pc_q    <= '0;
      redirect_q  <= '0;
      upd_hist_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        pt_q[i]   <= 1'b0;
        tgt_q[i]  <= '0;
        hist_q[i] <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      upd_valid_q <= res_fire;
      mis_q       <= mis;
      if (enq_fire && !mis) begin
        pc_q[tail_q]   <= enq_pc;
        pt_q[tail_q]   <= enq_pred_taken;
        tgt_q[tail_q]  <= enq_pred_target;
        hist_q[tail_q] <= enq_hist;
      end
      if (res_fire) begin
        upd_pc_q    <= head_pc;
        upd_taken_q <= res_taken;
        upd_hist_q  <= hist_q[head_q];
        redirect_q  <= res_taken ? res_target : head_pc + 32'd4;
      end
    end
  end

`ifdef BRQ_STATS_EN
  logic [31:0] stat_res_q, stat_mis_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (res_fire) stat_res_q <= stat_res_q + 32'd1;
      if (mis)      stat_mis_q <= stat_mis_q + 32'd1;
    end
  end
  assign stat_resolved = stat_res_q;
  assign stat_mispred  = stat_mis_q;
`endif

  assign upd_valid   = upd_valid_q;
  assign upd_pc      = upd_pc_q;
  assign upd_taken   = upd_taken_q;
  assign upd_hist    = upd_hist_q;
  assign mis_predict = mis_q;
  assign redirect_pc = redirect_q;
  assign count       = count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed testbench for branch_resolve_queue (DEPTH=4, HIST_LEN=4).
module tb_branch_resolve_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_pc = '0;
  logic        enq_pred_taken = 1'b0;
  logic [31:0] enq_pred_target = '0;
  logic [3:0]  enq_hist = '0;
  logic        enq_ready;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [3:0]  upd_hist;
  logic        mis_predict;
  logic [31:0] redirect_pc;
  logic [2:0]  count;
`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif

  int checks = 0;
  int failures = 0;

  branch_resolve_queue #(.DEPTH(4), .HIST_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred_taken(enq_pred_taken),
    .enq_pred_target(enq_pred_target), .enq_hist(enq_hist), .enq_ready(enq_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_hist(upd_hist),
    .mis_predict(mis_predict), .redirect_pc(redirect_pc),
`ifdef BRQ_STATS_EN
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [31:0] pc, input logic pt,
                         input logic [31:0] tgt, input logic [3:0] h);
    enq_valid = v; enq_pc = pc; enq_pred_taken = pt; enq_pred_target = tgt; enq_hist = h;
  endtask

  task automatic set_res(input logic v, input logic t, input logic [31:0] tgt);
    res_valid = v; res_taken = t; res_target = tgt;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_upd_valid"}, 32'(upd_valid), 32'd0);
    chk({tag, "_upd_pc"}, upd_pc, 32'd0);
    chk({tag, "_upd_taken"}, 32'(upd_taken), 32'd0);
    chk({tag, "_upd_hist"}, 32'(upd_hist), 32'd0);
    chk({tag, "_mis"}, 32'(mis_predict), 32'd0);
    chk({tag, "_redirect"}, redirect_pc, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_ready"}, 32'(enq_ready), 32'd1);
  endtask

  initial begin
    // Power-on reset
    #12;
    chk_outputs_zero("por");
    rst = 1'b0;
    step();

    // Correct prediction
    set_enq(1, 32'h100, 1, 32'h200, 4'b1010); step();
    chk("corr_count1", 32'(count), 32'd1);
    set_enq(0, 0, 0, 0, 0); set_res(1, 1, 32'h200); step();
    chk("corr_upd_valid", 32'(upd_valid), 32'd1);
    chk("corr_upd_pc", upd_pc, 32'h100);
    chk("corr_upd_taken", 32'(upd_taken), 32'd1);
    chk("corr_upd_hist", 32'(upd_hist), 32'hA);
    chk("corr_mis", 32'(mis_predict), 32'd0);
    chk("corr_count0", 32'(count), 32'd0);
    set_res(0, 0, 0); step();
    chk("corr_pulse_end", 32'(upd_valid), 32'd0);
    chk("corr_pc_hold", upd_pc, 32'h100);

    // Fill to full, fifth enqueue dropped
    for (int i = 0; i < 4; i++) begin
      set_enq(1, 32'h300 + 32'(i * 4), 0, 32'h0, 4'(i + 1)); step();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(enq_ready), 32'd0);
    set_enq(1, 32'h3F0, 0, 32'h0, 4'hF); step();
    chk("drop_count", 32'(count), 32'd4);
    set_enq(0, 0, 0, 0, 0);
    set_res(1, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_pc", upd_pc, 32'h300 + 32'(i * 4));
      chk("drain_hist", 32'(upd_hist), 32'(i + 1));
      chk("drain_mis", 32'(mis_predict), 32'd0);
    end
    set_res(0, 0, 0); step();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_idle", 32'(upd_valid), 32'd0);

    // Direction mispredict with flush and concurrent enqueue
    set_enq(1, 32'h100, 1, 32'h200, 4'h1); step();
    set_enq(1, 32'h110, 0, 32'h0, 4'h2); step();
    set_enq(1, 32'h120, 0, 32'h0, 4'h3); step();
    chk("dir_count3", 32'(count), 32'd3);
    set_enq(1, 32'h130, 0, 32'h0, 4'h4); set_res(1, 0, 32'h0); step();
    chk("dir_mis", 32'(mis_predict), 32'd1);
    chk("dir_redirect", redirect_pc, 32'h104);
    chk("dir_count0", 32'(count), 32'd0);
    chk("dir_upd_valid", 32'(upd_valid), 32'd1);
    chk("dir_upd_taken", 32'(upd_taken), 32'd0);
    chk("dir_upd_hist", 32'(upd_hist), 32'h1);
    set_enq(1, 32'h500, 0, 32'h0, 4'h5); set_res(0, 0, 0); step();
    chk("dir_mis_pulse_end", 32'(mis_predict), 32'd0);
    chk("post_flush_count", 32'(count), 32'd1);
    set_enq(0, 0, 0, 0, 0); set_res(1, 0, 32'h0); step();
    chk("post_flush_pc", upd_pc, 32'h500);
    chk("post_flush_mis", 32'(mis_predict), 32'd0);

    // Target mispredict
    set_enq(1, 32'h600, 1, 32'h200, 4'h6); set_res(0, 0, 0); step();
    set_enq(0, 0, 0, 0, 0); set_res(1, 1, 32'h240); step();
    chk("tgt_mis", 32'(mis_predict), 32'd1);
    chk("tgt_redirect", redirect_pc, 32'h240);
    chk("tgt_upd_taken", 32'(upd_taken), 32'd1);
    chk("tgt_upd_pc", upd_pc, 32'h600);
    set_res(0, 0, 0);

    // Asynchronous reset mid-operation while an update pulse is live
    set_enq(1, 32'h700, 0, 32'h0, 4'h7); step();
    set_enq(1, 32'h704, 0, 32'h0, 4'h8); step();
    set_enq(0, 0, 0, 0, 0); set_res(1, 0, 32'h0); step();
    chk("pre_rst_upd", 32'(upd_valid), 32'd1);
    set_res(0, 0, 0);
    #2; rst = 1'b1; #1;
    chk_outputs_zero("async_rst");
`ifdef BRQ_STATS_EN
    chk("rst_stat_res", stat_resolved, 32'd0);
    chk("rst_stat_mis", stat_mispred, 32'd0);
`endif
    #2; rst = 1'b0;
    step();
    chk("post_rst_upd", 32'(upd_valid), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);

    // Six in-order resolves through pointer wrap, overlapping enqueue and resolve
    set_enq(1, 32'h1000, 0, 32'h0, 4'h0); step();
    for (int i = 1; i < 6; i++) begin
      set_enq(1, 32'h1000 + 32'(i * 16), 0, 32'h0, 4'(i)); set_res(1, 0, 32'h0); step();
      chk("wrap_pc", upd_pc, 32'h1000 + 32'((i - 1) * 16));
      chk("wrap_count", 32'(count), 32'd1);
      chk("wrap_mis", 32'(mis_predict), 32'd0);
    end
    set_enq(0, 0, 0, 0, 0); set_res(1, 0, 32'h0); step();
    chk("wrap_last_pc", upd_pc, 32'h1050);
    chk("wrap_last_hist", 32'(upd_hist), 32'd5);
    chk("wrap_count0", 32'(count), 32'd0);
    step();
    chk("empty_res_upd", 32'(upd_valid), 32'd0);
    chk("empty_res_mis", 32'(mis_predict), 32'd0);
    chk("empty_res_pc_hold", upd_pc, 32'h1050);
    chk("empty_res_count", 32'(count), 32'd0);
`ifdef BRQ_STATS_EN
    chk("stat_resolved", stat_resolved, 32'd6);
    chk("stat_mispred", stat_mispred, 32'd0);
`endif
    set_res(0, 0, 0); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks every conditional branch the fetch stage predicts, in program order, until execute resolves it. On resolution it compares the recorded prediction with the actual outcome and drives the update pulse, PC, outcome and history snapshot into the global branch predictor. It also raises a one-cycle mispredict with the redirect PC for the fetch PC mux. The queue sits between the fetch-side predictor lookup and the execute-side branch comparator, and closes the predict/update loop.

## Interface
- `DEPTH`, 4: in-flight branch entries; power of two, ≥2.
- `HIST_LEN`, 4: width of the global-history snapshot; matches the predictor's history length.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `enq_valid` in 1: fetch pushes a predicted branch this cycle.
- `enq_pc` in 32: branch PC.
- `enq_pred_taken` in 1: predicted direction.
- `enq_pred_target` in 32: predicted target (ignored if not taken).
- `enq_hist` in HIST_LEN: history value used to form the predictor read index.
- `enq_ready` out 1: queue can accept; `= (count < DEPTH)`.
- `res_valid` in 1: execute resolves the oldest branch.
- `res_taken` in 1: actual direction (br_en).
- `res_target` in 32: actual taken target.
- `upd_valid` out 1: predictor update strobe (global_pred_update).
- `upd_pc` out 32: PC of the resolved branch.
- `upd_taken` out 1: actual outcome.
- `upd_hist` out HIST_LEN: snapshot for the write index.
- `mis_predict` out 1: one-cycle mispredict pulse.
- `redirect_pc` out 32: correct next PC, valid when `mis_predict`=1.
- `count` out $clog2(DEPTH+1): occupied entries.

## Operation
- The queue is a circular FIFO with head/tail pointers of $clog2(DEPTH) bits. Pointers wrap naturally. `count` is kept separately, so full and empty are unambiguous.
- **Enqueue:**
  - Fires when `enq_valid && enq_ready`. It writes entry{pc, pred_taken, pred_target, hist} at tail, then tail+1.
  - `enq_valid` while full is dropped. Fetch must stall on `!enq_ready`.
- **Resolve:**
  - Fires when `res_valid && count!=0`. It pops head.
  - `res_valid` with an empty queue is ignored: no update, no pulse.
- **Mispredict condition:** `pred_taken != res_taken`, or `(res_taken && pred_target != res_target)`.
- **Redirect PC:** `redirect_pc = res_taken ? res_target : pc + 32'd4`, computed with 32-bit wrap.
- **On mispredict, all entries are flushed:**
  - `count`←0 and tail←head+1; all younger entries are wrong-path.
  - An enqueue in the same cycle is discarded.
- **Simultaneous enq and resolve with no mispredict:** both take effect and `count` is unchanged. There is no bypass: an entry enqueued this cycle cannot be resolved this cycle.
- Every resolve produces exactly one update, whether or not it mispredicted.

## Timing
- **Reset values:**
  - `upd_valid`=0, `upd_pc`=0, `upd_taken`=0, `upd_hist`=0, `mis_predict`=0, `redirect_pc`=0.
  - `count`=0 and pointers=0, so `enq_ready`=1.
- Update and mispredict outputs are registered. A resolve in cycle N produces `upd_*`, `mis_predict` and `redirect_pc` in cycle N+1 for exactly one cycle. `upd_pc`, `upd_taken`, `upd_hist` and `redirect_pc` hold their values until the next resolve.
- `count` and `enq_ready` reflect state after the clock edge. An enqueue in cycle N is visible in `count` at N+1.
- Reset asserted mid-operation clears all entries and outputs immediately. No update or pulse is emitted for entries still in flight.

## Configuration
- **`BRQ_STATS_EN` defined:**
  - Adds outputs `stat_resolved` (32) and `stat_mispred` (32), reset to 0.
  - Each increments by one, registered alongside `upd_valid` and `mis_predict` respectively, and wraps at 2^32.
- **Not defined:** these ports and counters do not exist. All other behaviour is identical.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle -> all outputs 0, `count`=0, `enq_ready`=1 before the next edge.
- **Fill/full:** enqueue 4 branches back to back (DEPTH=4) -> `count`=4, `enq_ready`=0. A 5th `enq_valid` is dropped and `count` stays 4.
- **Correct prediction:**
  - Stimulus: enq pc=0x100, pred_taken=1, target=0x200, hist=4'b1010; resolve taken with target 0x200.
  - Response: next cycle `upd_valid`=1, `upd_pc`=0x100, `upd_taken`=1, `upd_hist`=4'b1010, `mis_predict`=0.
- **Direction mispredict with flush:**
  - Stimulus: 3 entries, head pc=0x100 pred_taken=1; resolve not taken, with an enq in the same cycle.
  - Response: next cycle `mis_predict`=1, `redirect_pc`=0x104, `count`=0; the concurrent enqueue is discarded.
- **Target mispredict:** pred_taken=1, target=0x200; resolve taken to 0x240 -> `mis_predict`=1, `redirect_pc`=0x240, `upd_taken`=1.
- **Wrap and empty resolve:**
  - Stimulus: 6 enq/resolve pairs with no mispredict, so pointers wrap; then `res_valid` on an empty queue.
  - Response: 6 in-order updates matching the enqueued PCs; no update for the empty resolve.
  - With `BRQ_STATS_EN`: `stat_resolved`=6, `stat_mispred`=0.
